// File: rtl/log_lane.sv
// Scrolling log sprite for one lane: frame-synchronous horizontal motion plus a
// two-stage registered pixel path (sprite ROM address, then palette/opacity).
module log_lane #(
    parameter logic [9:0]  LANE_Y  = 10'd96,
    parameter logic [10:0] START_X = 11'd0,
    parameter logic [3:0]  SPEED   = 4'd1,
    parameter logic        DIR     = 1'b1
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        frame_clk,
    input  logic        run,
    input  logic        restart,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic [7:0]  rom_data,
    output logic [6:0]  DX,
    output logic [6:0]  DY,
    output logic [7:0]  pix_color,
    output logic        pix_on,
    output logic [10:0] log_x
);

    localparam int unsigned XW     = 11;
    localparam int unsigned SPR_W  = 96;
    localparam int unsigned SPR_H  = 24;
    localparam int unsigned PERIOD = 736;

    localparam logic [XW-1:0] C_SPR_W  = XW'(SPR_W);
    localparam logic [XW-1:0] C_PERIOD = XW'(PERIOD);
    localparam logic [XW-1:0] C_SPEED  = XW'(SPEED);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_sync_d;
    logic [1:0]    r_warm;
    logic          w_frame_tick;

    logic [XW-1:0] r_log_x;
    logic [XW-1:0] w_sum;
    logic [XW-1:0] w_step_r;
    logic [XW-1:0] w_step_l;
    logic [XW-1:0] w_log_x_nxt;

    logic [XW-1:0] w_relx;
    logic [9:0]    w_rely;
    logic          w_hit1;
    logic          r_hit;
    logic [6:0]    r_dx;
    logic [6:0]    r_dy;
    logic [7:0]    r_pix_color;
    logic          r_pix_on;

    // frame_clk synchroniser; the edge detector's history flop stays high until
    // the synchroniser holds real samples, so a level already high at reset
    // release is never mistaken for a rising edge.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_warm   <= 2'b00;
            r_sync_d <= 1'b1;
        end else begin
            r_sync1  <= frame_clk;
            r_sync2  <= r_sync1;
            r_warm   <= {r_warm[0], 1'b1};
            r_sync_d <= r_warm[1] ? r_sync2 : 1'b1;
        end
    end

    assign w_frame_tick = r_sync2 & ~r_sync_d;

    // Next position: wrap within the 736-pixel virtual track.
    always_comb begin
        w_sum       = r_log_x + C_SPEED;
        w_step_r    = (w_sum >= C_PERIOD) ? (w_sum - C_PERIOD) : w_sum;
        w_step_l    = (r_log_x < C_SPEED) ? (r_log_x + C_PERIOD - C_SPEED)
                                          : (r_log_x - C_SPEED);
        w_log_x_nxt = r_log_x;
        if (restart) begin
            w_log_x_nxt = START_X;
        end else if (w_frame_tick && run) begin
            w_log_x_nxt = DIR ? w_step_r : w_step_l;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_log_x <= START_X;
        end else begin
            r_log_x <= w_log_x_nxt;
        end
    end

    // Stage 1 hit test; a column left of the sprite wraps to a large relx and
    // so fails the bound, which clips both screen edges without artefacts.
    always_comb begin
        w_relx = {1'b0, DrawX} + C_SPR_W - r_log_x;
        w_rely = DrawY - LANE_Y;
        w_hit1 = (w_relx < C_SPR_W) && (DrawY >= LANE_Y) && (w_rely < 10'(SPR_H));
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_hit <= 1'b0;
            r_dx  <= 7'd0;
            r_dy  <= 7'd0;
        end else begin
            r_hit <= w_hit1;
            r_dx  <= w_hit1 ? w_relx[6:0] : 7'd0;
            r_dy  <= w_hit1 ? w_rely[6:0] : 7'd0;
        end
    end

    // Stage 2: palette index 0 is transparent.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_pix_color <= 8'd0;
            r_pix_on    <= 1'b0;
        end else begin
            r_pix_color <= r_hit ? rom_data : 8'd0;
            r_pix_on    <= r_hit && (rom_data != 8'd0);
        end
    end

    assign DX        = r_dx;
    assign DY        = r_dy;
    assign pix_color = r_pix_color;
    assign pix_on    = r_pix_on;
    assign log_x     = r_log_x;

endmodule
